key_input_fifo: RTL and testbench
=================================

// Module: key_input_fifo
// PURPOSE
//   Consumes the one-cycle debounced key-press pulse and captures the switch bank into a small FIFO.
//   Sits between the key debouncer and the CPU IO read port.
//   The CPU pops entries via an IO read strobe, so presses made before the program polls are not lost.
//   Reports empty/full/count status; optionally reports a sticky overflow flag.
// PARAMETERS
//   DATA_W  16  width of captured switch word
//   DEPTH   4   FIFO entries; power of two, >=2
//   ADDR_W  2   log2(DEPTH); pointer width
// PORTS
//   clk       in   1         system clock, all logic posedge
//   rst       in   1         asynchronous, active-low reset
//   key_pulse in   1         debounced press pulse from key debouncer
//   sw_data   in   DATA_W    switch bank value, sampled on accepted push
//   io_rd     in   1         CPU read strobe, one cycle per pop
//   rd_data   out  DATA_W    head entry (first-word-fall-through), 0 when empty
//   empty     out  1         count==0
//   full      out  1         count==DEPTH
//   count     out  ADDR_W+1  entries held, 0..DEPTH
//   overflow  out  1         sticky lost-press flag   [KEY_FIFO_OVF_EN only]
//   ovf_clr   in   1         clears overflow          [KEY_FIFO_OVF_EN only]
// BEHAVIOUR
//   - Reset (rst=0, async): wr_ptr=rd_ptr=0, count=0, rd_data=0, empty=1, full=0, overflow=0, edge-detect reg=0.
//   - Push event: rising edge of key_pulse, push = key_pulse & ~key_pulse_d.
//     - A pulse held high N cycles yields exactly one push.
//   - Accepted push: push & (~full | pop).
//     - Writes sw_data at wr_ptr; wr_ptr+1 mod DEPTH.
//     - Entry is visible on rd_data/count the cycle after the push edge (1-cycle latency).
//   - Pop: io_rd & ~empty.
//     - rd_ptr+1 mod DEPTH; rd_data shows the next entry the following cycle.
//     - io_rd while empty is ignored; no pointer/count change.
//   - Simultaneous push+pop:
//     - Not empty: both occur, count unchanged.
//     - Full: both occur; the new word lands in the slot freed by the pop; full stays 1.
//     - Empty: pop ignored, push occurs, count=1.
//   - count: +1 on push-only, -1 on pop-only, else hold; never exceeds DEPTH, never goes below 0.
//   - Pointers wrap silently at DEPTH; full/empty are derived from count, not pointer compare.
//   - rd_data is combinational from mem[rd_ptr] gated by ~empty.
//     - It never shows stale data after the last pop (0 when empty).
//   - Reset mid-operation discards all entries; mem contents need not be cleared.
// CONFIGURATION
//   KEY_FIFO_OVF_EN defined:
//     - overflow and ovf_clr ports exist.
//     - overflow is set the cycle after push & full & ~pop.
//     - overflow is cleared the cycle after ovf_clr; set wins if both occur in the same cycle.
//     - Holds until cleared or reset.
//   KEY_FIFO_OVF_EN undefined:
//     - Ports and logic are absent.
//     - A dropped push is silently discarded; all other behaviour is identical.
// TESTING  (DEPTH=4, DATA_W=16)
//   1. Reset, no stimulus -> empty=1, full=0, count=0, rd_data=0x0000.
//   2. Three pushes sw=0x0011,0x0022,0x0033, then 3 io_rd
//      -> rd_data 0x0011,0x0022,0x0033 in order; count 3->0; empty=1.
//   3. key_pulse held high 5 cycles with sw=0x00A5 -> count=1, rd_data=0x00A5 (single push).
//   4. Fill 4 entries (0x1..0x4), push 0x5 -> count=4, full=1, head=0x1, overflow=1 (OVF_EN);
//      pulse ovf_clr -> overflow=0.
//   5. Full FIFO, push 0x9 with io_rd in the same cycle
//      -> count=4, full=1, overflow=0, pop order 0x2,0x3,0x4,0x9.
//   6. Two entries held, assert rst=0 mid-push -> count=0, empty=1, rd_data=0 immediately.
//      After release, push 0x7 -> rd_data=0x7 (wrap and pointer reset verified).

Source files
------------

// File: rtl/key_input_fifo.sv
// key_input_fifo: captures the switch bank on each debounced key press into a small FWFT FIFO popped by CPU IO reads; optional sticky overflow flag under KEY_FIFO_OVF_EN
module key_input_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_pulse,
  input  logic [DATA_W-1:0] sw_data,
  input  logic              io_rd,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count
`ifdef KEY_FIFO_OVF_EN
  ,
  input  logic              ovf_clr,
  output logic              overflow
`endif
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              key_d, push, pop, wr_en;
  assign push    = key_pulse & ~key_d;
  assign pop     = io_rd & ~empty;
  assign wr_en   = push & (~full | pop);
  assign empty   = count == '0;
  assign full    = count == (ADDR_W+1)'(DEPTH);
  assign rd_data = empty ? '0 : mem[rd_ptr];
  // edge detect, pointers and occupancy; full/empty come from count so wrap is harmless
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_d  <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      key_d  <= key_pulse;
      wr_ptr <= wr_en ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count  <= (wr_en & ~pop) ? count + 1'b1 : (pop & ~wr_en) ? count - 1'b1 : count;
    end
  end
  // storage; when full with a pop, wr_ptr equals rd_ptr so the new word takes the freed slot
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= sw_data;
  end
`ifdef KEY_FIFO_OVF_EN
  // sticky lost-press flag; a new loss wins over a same-cycle clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) overflow <= 1'b0;
    else overflow <= (push & full & ~pop) ? 1'b1 : ovf_clr ? 1'b0 : overflow;
  end
`endif
endmodule

// File: tb/tb_key_input_fifo.sv
// tb_key_input_fifo: directed checks of key_input_fifo (DEPTH=4, DATA_W=16)
module tb_key_input_fifo;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        key_pulse = 1'b0;
  logic [15:0] sw_data = '0;
  logic        io_rd = 1'b0;
  logic [15:0] rd_data;
  logic        empty, full;
  logic [2:0]  count;
`ifdef KEY_FIFO_OVF_EN
  logic        ovf_clr = 1'b0;
  logic        overflow;
`endif
  int total = 0;
  int fails = 0;

  key_input_fifo #(.DATA_W(16), .DEPTH(4), .ADDR_W(2)) dut (
    .clk(clk), .rst(rst), .key_pulse(key_pulse), .sw_data(sw_data), .io_rd(io_rd),
    .rd_data(rd_data), .empty(empty), .full(full), .count(count)
`ifdef KEY_FIFO_OVF_EN
    , .ovf_clr(ovf_clr), .overflow(overflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [15:0] v);
    sw_data = v;
    key_pulse = 1'b1;
    step();
    key_pulse = 1'b0;
    step();
  endtask

  task automatic pop();
    io_rd = 1'b1;
    step();
    io_rd = 1'b0;
  endtask

  initial begin
    step();
    step();
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
`ifdef KEY_FIFO_OVF_EN
    chk("rst_overflow", 32'(overflow), 0);
`endif
    rst = 1'b1;
    step();
    chk("idle_empty", 32'(empty), 1);
    chk("idle_count", 32'(count), 0);

    // three pushes, three pops
    sw_data = 16'h0011;
    key_pulse = 1'b1;
    step();
    chk("t2_latency_count", 32'(count), 1);
    chk("t2_latency_data", 32'(rd_data), 32'h11);
    key_pulse = 1'b0;
    step();
    push(16'h0022);
    push(16'h0033);
    chk("t2_count3", 32'(count), 3);
    chk("t2_head0", 32'(rd_data), 32'h11);
    pop();
    chk("t2_head1", 32'(rd_data), 32'h22);
    chk("t2_count2", 32'(count), 2);
    pop();
    chk("t2_head2", 32'(rd_data), 32'h33);
    chk("t2_count1", 32'(count), 1);
    pop();
    chk("t2_count0", 32'(count), 0);
    chk("t2_empty", 32'(empty), 1);
    chk("t2_rd_zero", 32'(rd_data), 0);
    pop();
    chk("t2_rd_empty_ignored", 32'(count), 0);

    // held pulse yields one push
    sw_data = 16'h00A5;
    key_pulse = 1'b1;
    for (int i = 0; i < 5; i++) step();
    key_pulse = 1'b0;
    step();
    chk("t3_count", 32'(count), 1);
    chk("t3_data", 32'(rd_data), 32'hA5);
    pop();
    chk("t3_drained", 32'(empty), 1);

    // fill and overflow
    push(16'h0001);
    push(16'h0002);
    push(16'h0003);
    push(16'h0004);
    chk("t4_full_before", 32'(full), 1);
    push(16'h0005);
    chk("t4_count", 32'(count), 4);
    chk("t4_full", 32'(full), 1);
    chk("t4_head", 32'(rd_data), 32'h1);
`ifdef KEY_FIFO_OVF_EN
    chk("t4_overflow_set", 32'(overflow), 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("t4_overflow_clr", 32'(overflow), 0);
`endif

    // push with pop while full
    sw_data = 16'h0009;
    key_pulse = 1'b1;
    io_rd = 1'b1;
    step();
    key_pulse = 1'b0;
    io_rd = 1'b0;
    step();
    chk("t5_count", 32'(count), 4);
    chk("t5_full", 32'(full), 1);
`ifdef KEY_FIFO_OVF_EN
    chk("t5_overflow", 32'(overflow), 0);
`endif
    chk("t5_pop0", 32'(rd_data), 32'h2);
    pop();
    chk("t5_pop1", 32'(rd_data), 32'h3);
    pop();
    chk("t5_pop2", 32'(rd_data), 32'h4);
    pop();
    chk("t5_pop3", 32'(rd_data), 32'h9);
    pop();
    chk("t5_empty", 32'(empty), 1);

    // async reset mid-push
    push(16'h000B);
    push(16'h000C);
    chk("t6_count2", 32'(count), 2);
    sw_data = 16'h000D;
    key_pulse = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rst_count", 32'(count), 0);
    chk("t6_rst_empty", 32'(empty), 1);
    chk("t6_rst_rd_data", 32'(rd_data), 0);
    key_pulse = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("t6_post_rst_count", 32'(count), 0);
    push(16'h0007);
    chk("t6_new_data", 32'(rd_data), 32'h7);
    chk("t6_new_count", 32'(count), 1);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
